// File: rtl/riscv_retire_trace_pkg.sv
// rtl/riscv_retire_trace_pkg.sv - shared widths, trace entry type and helpers
//
// Purpose : common definitions for the retire-trace collector and its FIFO.
// Ports   : none (package).

`ifndef TRACE_PC_W
`define TRACE_PC_W 32
`endif
`ifndef TRACE_SEQ_W
`define TRACE_SEQ_W 32
`endif

package riscv_retire_trace_pkg;

   localparam int PC_W  = `TRACE_PC_W;
   localparam int SEQ_W = `TRACE_SEQ_W;

   // One serialised retirement: PC plus the sequence number it consumed.
   typedef struct packed {
      logic [PC_W-1:0]  pc;
      logic [SEQ_W-1:0] seq;
   } trace_entry_t;

   // Population count of two strobes, used for push/drop/seq arithmetic.
   function automatic logic [1:0] count2(input logic a, input logic b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/riscv_retire_trace_if.sv
// rtl/riscv_retire_trace_if.sv - trace output stream interface
//
// Purpose : valid/ready stream carrying the head trace entry to the sink.
// Signals : valid - head entry available
//           pc    - head entry PC
//           seq   - head entry sequence number
//           ready - sink accepts the head entry
// Modports: master (collector side), slave (sink side).

interface riscv_retire_trace_if;
   import riscv_retire_trace_pkg::*;

   logic             valid;
   logic [PC_W-1:0]  pc;
   logic [SEQ_W-1:0] seq;
   logic             ready;

   modport master (output valid, output pc, output seq, input ready);
   modport slave  (input valid, input pc, input seq, output ready);
endinterface

// File: rtl/riscv_trace_fifo.sv
// rtl/riscv_trace_fifo.sv - 2-write/1-read synchronous FIFO for trace entries
//
// Purpose : stores trace entries; up to two writes and one read per cycle.
// Ports   : clk, rst       - clock, synchronous active-high reset
//           push0, data0   - write the older entry
//           push1, data1   - write the younger entry (lands after data0 if both)
//           pop            - remove the head entry (ignored when empty)
//           head, empty    - head entry (zero when empty) and empty flag
//           level, free    - occupancy and free slots at the start of the cycle

module riscv_trace_fifo
   import riscv_retire_trace_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push0,
   input  trace_entry_t data0,
   input  logic         push1,
   input  trace_entry_t data1,
   input  logic         pop,
   output trace_entry_t head,
   output logic         empty,
   output logic [AW:0]  level,
   output logic [AW:0]  free
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          full;
   logic          do_pop;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;

   trace_entry_t mem [DEPTH];

   assign empty  = (wr_ptr == rd_ptr);
   assign full   = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
   assign level  = wr_ptr - rd_ptr;
   assign free   = full ? '0 : (DEPTH[AW:0] - level);
   assign do_pop = pop & ~empty;

   // The younger entry goes one slot past the older one; the AW-bit add
   // wraps naturally across the array end because DEPTH is a power of two.
   assign addr0 = wr_ptr[AW-1:0];
   assign addr1 = wr_ptr[AW-1:0] + {{(AW-1){1'b0}}, push0};

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + {{AW{1'b0}}, push0} + {{AW{1'b0}}, push1};
         rd_ptr <= rd_ptr + {{AW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push0) mem[addr0] <= data0;
      if (push1) mem[addr1] <= data1;
   end

   // Zero when empty so the head reads as zero straight out of reset.
   assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/riscv_retire_trace.sv
// rtl/riscv_retire_trace.sv - dual-issue retire event serialiser with statistics
//
// Purpose : serialises pipe0/pipe1 retirements (oldest first) into a sequence-
//           tagged trace stream and keeps retire/drop statistics.
// Ports   : clk_i, rst_i            - clock, synchronous active-high reset
//           enable_i                - capture enable
//           clear_i                 - clears overflow_o and drop_count_o
//           pipe0_valid_i/pc_i      - older retirement slot
//           pipe1_valid_i/pc_i      - younger retirement slot
//           trace (master)          - valid/pc/seq/ready output stream
//           level_o                 - FIFO occupancy
//           overflow_o              - sticky drop indicator
//           retired_count_o         - retirements seen while enabled
//           drop_count_o            - saturating dropped-retirement count

module riscv_retire_trace
   import riscv_retire_trace_pkg::*;
#(
   parameter  int DEPTH = 16,
   parameter  int CNT_W = 16,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic                  clear_i,
   input  logic                  pipe0_valid_i,
   input  logic [PC_W-1:0]       pipe0_pc_i,
   input  logic                  pipe1_valid_i,
   input  logic [PC_W-1:0]       pipe1_pc_i,
   riscv_retire_trace_if.master  trace,
   output logic [LW-1:0]         level_o,
   output logic                  overflow_o,
   output logic [63:0]           retired_count_o,
   output logic [CNT_W-1:0]      drop_count_o
);

   logic             v0;
   logic             v1;
   logic             acc0;
   logic             acc1;
   logic [1:0]       needed;
   logic [1:0]       accepted;
   logic [1:0]       dropped;
   logic [LW-1:0]    free;
   logic             empty;
   trace_entry_t     entry0;
   trace_entry_t     entry1;
   trace_entry_t     head;
   logic [SEQ_W-1:0] seq_q;
   logic [CNT_W-1:0] drop_base;
   logic [CNT_W:0]   drop_sum;
   logic [CNT_W-1:0] drop_next;

   assign v0     = enable_i & pipe0_valid_i;
   assign v1     = enable_i & pipe1_valid_i;
   assign needed = count2(v0, v1);

   // Capacity is judged on start-of-cycle free slots; a same-cycle pop is
   // deliberately not credited. With one slot left and both valid, only the
   // older pipe0 entry fits.
   assign acc0     = v0 & (free != '0);
   assign acc1     = v1 & (free >= {{(LW-2){1'b0}}, needed});
   assign accepted = count2(acc0, acc1);
   assign dropped  = needed - accepted;

   // Every enabled retirement consumes a seq value, pipe0 first, so pipe1
   // takes seq_q+1 only when pipe0 also retired.
   assign entry0.pc  = pipe0_pc_i;
   assign entry0.seq = seq_q;
   assign entry1.pc  = pipe1_pc_i;
   assign entry1.seq = seq_q + {{(SEQ_W-1){1'b0}}, v0};

   riscv_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push0 (acc0),
      .data0 (entry0),
      .push1 (acc1),
      .data1 (entry1),
      .pop   (trace.ready),
      .head  (head),
      .empty (empty),
      .level (level_o),
      .free  (free)
   );

   assign trace.valid = ~empty;
   assign trace.pc    = head.pc;
   assign trace.seq   = head.seq;

   // A same-cycle clear restarts the count from zero, so the result is just
   // this cycle's drops: the drop wins over the clear.
   assign drop_base = clear_i ? '0 : drop_count_o;
   assign drop_sum  = {1'b0, drop_base} + {{(CNT_W-1){1'b0}}, dropped};
   assign drop_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         seq_q           <= '0;
         retired_count_o <= '0;
         overflow_o      <= 1'b0;
         drop_count_o    <= '0;
      end else begin
         seq_q           <= seq_q + {{(SEQ_W-2){1'b0}}, needed};
         retired_count_o <= retired_count_o + {62'd0, needed};
         if (dropped != 2'd0) begin
            overflow_o   <= 1'b1;
            drop_count_o <= drop_next;
         end else if (clear_i) begin
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_riscv_retire_trace.sv
// tb/tb_riscv_retire_trace.sv - scoreboard bench for riscv_retire_trace

module tb_riscv_retire_trace;
   import riscv_retire_trace_pkg::*;

   localparam int DEPTH = 16;
   localparam int CNT_W = 4;
   localparam int LW    = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             enable = 1'b1;
   logic             clear = 1'b0;
   logic             p0v = 1'b0;
   logic             p1v = 1'b0;
   logic [31:0]      p0pc = '0;
   logic [31:0]      p1pc = '0;
   logic [LW-1:0]    level;
   logic             overflow;
   logic [63:0]      retired;
   logic [CNT_W-1:0] drops;

   riscv_retire_trace_if tif ();

   riscv_retire_trace #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .enable_i        (enable),
      .clear_i         (clear),
      .pipe0_valid_i   (p0v),
      .pipe0_pc_i      (p0pc),
      .pipe1_valid_i   (p1v),
      .pipe1_pc_i      (p1pc),
      .trace           (tif),
      .level_o         (level),
      .overflow_o      (overflow),
      .retired_count_o (retired),
      .drop_count_o    (drops)
   );

   always #5 clk = ~clk;

   int           vectors = 0;
   int           miscompares = 0;
   trace_entry_t exp_q[$];
   logic         stall_prev = 1'b0;
   trace_entry_t held;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_entry(input logic [31:0] pc, input logic [31:0] seq);
      trace_entry_t e;
      e.pc  = pc;
      e.seq = seq;
      exp_q.push_back(e);
   endtask

   task automatic retire(input logic a, input logic [31:0] pa,
                         input logic b, input logic [31:0] pb);
      p0v = a; p0pc = pa; p1v = b; p1pc = pb;
      tick();
      p0v = 1'b0; p1v = 1'b0;
   endtask

   task automatic drain(input string name);
      tif.ready = 1'b1;
      for (int i = 0; i < 60 && (exp_q.size() != 0 || tif.valid); i++) tick();
      chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
      chk({name, "_level_zero"}, 64'(level), 64'd0);
      tif.ready = 1'b0;
   endtask

   // Monitor: pops the scoreboard on each accepted beat and checks that the
   // head holds steady across stalled cycles.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else if (tif.valid) begin
         if (stall_prev)
            chk("stall_stable", {tif.pc, tif.seq}, held);
         if (tif.ready) begin
            stall_prev = 1'b0;
            if (exp_q.size() == 0)
               chk("unexpected_beat", {tif.pc, tif.seq}, 64'hDEAD_DEAD_DEAD_DEAD);
            else
               chk("head", {tif.pc, tif.seq}, exp_q.pop_front());
         end else begin
            stall_prev = 1'b1;
            held.pc    = tif.pc;
            held.seq   = tif.seq;
         end
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      tif.ready = 1'b0;
      tick(); tick();
      chk("rst_valid", 64'(tif.valid), 0);
      chk("rst_pc", 64'(tif.pc), 0);
      chk("rst_seq", 64'(tif.seq), 0);
      chk("rst_level", 64'(level), 0);
      chk("rst_overflow", 64'(overflow), 0);
      chk("rst_retired", retired, 0);
      chk("rst_drops", 64'(drops), 0);
      rst = 1'b0;
      tick();

      // Single retire: visible one cycle after the push.
      p0v = 1'b1; p0pc = 32'h8000_0000;
      #1 chk("t1_valid_same_cycle", 64'(tif.valid), 0);
      expect_entry(32'h8000_0000, 0);
      tick();
      p0v = 1'b0;
      chk("t1_valid_next", 64'(tif.valid), 1);
      chk("t1_level", 64'(level), 1);
      chk("t1_retired", retired, 1);
      drain("t1");

      // Dual retire with ready high: pipe0 then pipe1, level peaks at 2.
      tif.ready = 1'b1;
      expect_entry(32'h8000_0010, 1);
      expect_entry(32'h8000_0014, 2);
      retire(1, 32'h8000_0010, 1, 32'h8000_0014);
      chk("t2_level_peak", 64'(level), 2);
      tick();
      chk("t2_level_1", 64'(level), 1);
      tick();
      chk("t2_level_0", 64'(level), 0);
      chk("t2_retired", retired, 3);
      tif.ready = 1'b0;

      // Fill to DEPTH-1, then dual: pipe1 dropped; then dual on full: both dropped.
      for (int i = 0; i < 15; i++) begin
         expect_entry(32'h8000_1000 + 32'(4 * i), 32'(3 + i));
         retire(1, 32'h8000_1000 + 32'(4 * i), 0, 0);
      end
      chk("t3_level_15", 64'(level), 15);
      expect_entry(32'h8000_2000, 18);
      retire(1, 32'h8000_2000, 1, 32'h8000_2004);
      chk("t3_overflow", 64'(overflow), 1);
      chk("t3_drops_1", 64'(drops), 1);
      chk("t3_level_16", 64'(level), 16);
      chk("t3_retired", retired, 20);
      retire(1, 32'h8000_2008, 1, 32'h8000_200C);
      chk("t3_drops_3", 64'(drops), 3);
      chk("t3_level_full", 64'(level), 16);
      chk("t3_retired_22", retired, 22);
      drain("t3");

      // Backpressure: ready 1,0,0,1 while the head steps to 0x800000A0.
      expect_entry(32'h8000_009C, 22);
      expect_entry(32'h8000_00A0, 23);
      retire(1, 32'h8000_009C, 1, 32'h8000_00A0);
      chk("t4_level_2", 64'(level), 2);
      tif.ready = 1'b1; tick();
      chk("t4_pop_r1", 64'(level), 1);
      tif.ready = 1'b0; tick();
      chk("t4_hold_r0a", 64'(level), 1);
      tick();
      chk("t4_hold_r0b", 64'(level), 1);
      chk("t4_hold_pc", 64'(tif.pc), 64'h8000_00A0);
      tif.ready = 1'b1; tick();
      chk("t4_pop_r1b", 64'(level), 0);
      tif.ready = 1'b0;

      clear = 1'b1; tick(); clear = 1'b0;
      chk("t5_clr_drops", 64'(drops), 0);
      chk("t5_clr_overflow", 64'(overflow), 0);

      // Saturation: fill (pairs wrap across the array end), then 20 drops.
      for (int i = 0; i < 8; i++) begin
         expect_entry(32'h8000_5000 + 32'(8 * i), 32'(24 + 2 * i));
         expect_entry(32'h8000_5004 + 32'(8 * i), 32'(25 + 2 * i));
         retire(1, 32'h8000_5000 + 32'(8 * i), 1, 32'h8000_5004 + 32'(8 * i));
      end
      chk("t5_level_full", 64'(level), 16);
      for (int i = 0; i < 10; i++) retire(1, 32'h8000_6000, 1, 32'h8000_6004);
      chk("t5_drops_sat", 64'(drops), 15);
      chk("t5_overflow", 64'(overflow), 1);
      chk("t5_retired", retired, 60);
      clear = 1'b1;
      retire(1, 32'h8000_6008, 1, 32'h8000_600C);
      clear = 1'b0;
      chk("t5_clear_vs_drop_cnt", 64'(drops), 2);
      chk("t5_clear_vs_drop_ovf", 64'(overflow), 1);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("t5_clear_drops", 64'(drops), 0);
      chk("t5_clear_overflow", 64'(overflow), 0);

      // Disabled capture: nothing changes; draining still works.
      enable = 1'b0;
      for (int i = 0; i < 5; i++) retire(1, 32'h8000_7000, 1, 32'h8000_7004);
      chk("t6_level", 64'(level), 16);
      chk("t6_retired", retired, 62);
      chk("t6_drops", 64'(drops), 0);
      drain("t6");
      enable = 1'b1;
      expect_entry(32'h8000_3000, 62);
      retire(1, 32'h8000_3000, 0, 0);
      drain("t6b");

      // Reset with three queued entries.
      retire(1, 32'h8000_3010, 1, 32'h8000_3014);
      retire(1, 32'h8000_3018, 0, 0);
      chk("t7_level_3", 64'(level), 3);
      rst = 1'b1; tick();
      chk("t7_valid", 64'(tif.valid), 0);
      chk("t7_pc", 64'(tif.pc), 0);
      chk("t7_seq", 64'(tif.seq), 0);
      chk("t7_level", 64'(level), 0);
      chk("t7_retired", retired, 0);
      chk("t7_overflow", 64'(overflow), 0);
      chk("t7_drops", 64'(drops), 0);
      rst = 1'b0;
      expect_entry(32'h8000_4000, 0);
      retire(0, 0, 1, 32'h8000_4000);
      chk("t7_retired_1", retired, 1);
      drain("t7");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/riscv_retire_trace.md
Name: riscv_retire_trace

Overview:
Commit-trace collector sitting directly downstream of riscv_core's dual-issue writeback stage. It consumes the per-cycle retire events of pipe0 and pipe1 (valid + PC) and serialises them, oldest first, into a single valid/ready stream tagged with a sequence number. It also keeps retire and drop statistics. The stream feeds a trace sink (bench file writer or debug port), replacing ad-hoc hierarchical probing of the issue stage.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 4
CNT_W, 16, width of the saturating drop counter

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous, active-high reset
enable_i  input  1  capture enable; when low, retire events are ignored entirely
clear_i  input  1  single-cycle pulse; clears overflow_o and drop_count_o
pipe0_valid_i  input  1  pipe0 retired an instruction this cycle (older slot)
pipe0_pc_i  input  32  PC of the pipe0 retirement
pipe1_valid_i  input  1  pipe1 retired an instruction this cycle (younger slot)
pipe1_pc_i  input  32  PC of the pipe1 retirement
trace_valid_o  output  1  head entry available
trace_pc_o  output  32  head entry PC
trace_seq_o  output  32  head entry sequence number
trace_ready_i  input  1  sink accepts the head entry
level_o  output  log2(DEPTH)+1  current occupancy
overflow_o  output  1  sticky: at least one retirement dropped
retired_count_o  output  64  total retirements seen while enabled
drop_count_o  output  CNT_W  saturating count of dropped retirements

Behaviour:
- Reset: FIFO empty; trace_valid_o=0, trace_pc_o=0, trace_seq_o=0, level_o=0, overflow_o=0, retired_count_o=0, drop_count_o=0. The internal seq counter resets to 0. Reset mid-stream discards all entries.
- Ordering: pipe0 is always older than pipe1 in the same cycle. If both are valid, pipe0 is enqueued first. pipe1 alone is enqueued as a single entry.
- Sequence: every retirement seen while enabled consumes one seq value (pipe0 before pipe1), whether accepted or dropped. seq is 32-bit and wraps 0xFFFFFFFF to 0. Gaps in trace_seq_o therefore expose drops.
- Capacity check uses the occupancy at the start of the cycle and ignores a same-cycle pop (conservative):
  - free ≥ needed: push all.
  - free == 1 and both valid: push pipe0, drop pipe1.
  - free == 0: drop all.
  - Any drop sets overflow_o (sticky) and adds the number dropped to drop_count_o, saturating at all-ones.
- clear_i: overflow_o and drop_count_o are cleared next cycle. If a drop occurs in the same cycle, the drop wins: overflow_o=1 and drop_count_o equals that cycle's drop count.
- Latency: an entry pushed in cycle N appears on trace_valid_o/pc/seq in cycle N+1 at the earliest. Head outputs come straight from the storage array at the read pointer.
- Handshake: pop when trace_valid_o && trace_ready_i. Head outputs hold stable while trace_valid_o=1 and trace_ready_i=0. When empty, trace_pc_o/trace_seq_o are don't-care (the bench must not check them).
- level_o = pushes minus pops, exact every cycle. Simultaneous pop and push (0/1/2) updates level by the net value.
- retired_count_o increments by 0/1/2 per enabled cycle (accepted plus dropped); 64-bit wrap.
- enable_i low: no push, no seq advance, no count change. Popping continues.
- Pointers are log2(DEPTH)+1 bits; full is detected when the pointers differ only in the MSB. Write of two entries wraps across the array end correctly.

Decomposition:
- Shared defines file (existing core defs include): `TRACE_PC_W 32, `TRACE_SEQ_W 32.
- One sub-module: riscv_trace_fifo, a 2-write/1-read synchronous FIFO with a parameterised DEPTH. It exposes free-count and level, and takes push0/push1/pop strobes.
- The top holds the seq counter, drop/overflow logic and statistics.

Test Plan:
- Single retire: pipe0 valid, PC=0x80000000 at cycle 1 -> trace_valid_o=1 at cycle 2, pc=0x80000000, seq=0; retired_count_o=1.
- Dual retire: both valid, PC0=0x80000010, PC1=0x80000014, ready=1 -> two consecutive outputs in that order with seq 0, 1; level_o peaks at 2.
- Fill to DEPTH-1 with ready=0, then a dual retire -> pipe0 accepted, pipe1 dropped. overflow_o=1, drop_count_o=1, level_o=16. After draining, the seq gap is visible (the last accepted seq is 15; seq 16 is missing).
- Backpressure: ready toggles 1,0,0,1 while the head holds PC=0x800000A0 -> outputs stable during the stall; pop happens exactly on the ready=1 cycles.
- Saturation and clear: with CNT_W=4, force 20 drops -> drop_count_o=15. Pulse clear_i -> drop_count_o=0 and overflow_o=0 next cycle.
- enable_i=0 with both pipes valid for 5 cycles -> level_o, retired_count_o and seq unchanged. Assert rst_i with 3 queued entries -> next cycle all outputs are at reset values.
